// File: rtl/prirv32_exu.sv
// prirv32_exu: single-cycle execute stage of the priRV32 RV32I core.
//
// Takes a one-hot decoded instruction plus operands, immediate and PC, and
// produces a registered result one cycle later: register writeback, branch or
// jump redirect, or a load/store request for the LSU.
//
// Ports:
//   clk_i             core clock, rising edge
//   rst_n             synchronous reset, asserted HIGH (legacy name)
//   instrset_latched  one-hot decoded instruction (bit 0 LUI .. bit 36 AND)
//   imm_decoded       sign-extended immediate (pre-shifted for LUI/AUIPC)
//   rs1/rs2_decoded   source operand values
//   pc_latched        instruction PC
//   rd_reg, rs1_reg, rs2_reg  register indices
//   rd_*_o            writeback index/data/enable
//   branch_o, branch_target_o  PC redirect
//   mem_*_o           load/store request (address, lane-replicated data,
//                     strobes, size, zero-extend flag)
//   illegal_o         instruction vector had more than one bit set
//   misalign_o        misaligned target/address (only when checking enabled)
//   rs1_idx_o, rs2_idx_o  registered source indices for hazard logic
//
// Optional feature: define PRIRV32_EXU_MISALIGN_CHECK_EN to flag misaligned
// jump/branch targets and memory addresses and suppress their side effects.
// Without it misalign_o is tied low.

module prirv32_exu (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [36:0] instrset_latched,
  input  logic [31:0] imm_decoded,
  input  logic [31:0] rs1_decoded,
  input  logic [31:0] rs2_decoded,
  input  logic [31:0] pc_latched,
  input  logic [4:0]  rd_reg,
  input  logic [4:0]  rs1_reg,
  input  logic [4:0]  rs2_reg,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_wdata_o,
  output logic        rd_we_o,
  output logic        branch_o,
  output logic [31:0] branch_target_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  output logic [1:0]  mem_size_o,
  output logic        mem_unsigned_o,
  output logic        illegal_o,
  output logic        misalign_o,
  output logic [4:0]  rs1_idx_o,
  output logic [4:0]  rs2_idx_o
);

  localparam int unsigned OpLui   = 0;
  localparam int unsigned OpAuipc = 1;
  localparam int unsigned OpJal   = 2;
  localparam int unsigned OpJalr  = 3;
  localparam int unsigned OpBeq   = 4;
  localparam int unsigned OpBne   = 5;
  localparam int unsigned OpBlt   = 6;
  localparam int unsigned OpBge   = 7;
  localparam int unsigned OpBltu  = 8;
  localparam int unsigned OpBgeu  = 9;
  localparam int unsigned OpLb    = 10;
  localparam int unsigned OpLh    = 11;
  localparam int unsigned OpLw    = 12;
  localparam int unsigned OpLbu   = 13;
  localparam int unsigned OpLhu   = 14;
  localparam int unsigned OpSb    = 15;
  localparam int unsigned OpSh    = 16;
  localparam int unsigned OpSw    = 17;
  localparam int unsigned OpAddi  = 18;
  localparam int unsigned OpSlti  = 19;
  localparam int unsigned OpSltiu = 20;
  localparam int unsigned OpXori  = 21;
  localparam int unsigned OpOri   = 22;
  localparam int unsigned OpAndi  = 23;
  localparam int unsigned OpSlli  = 24;
  localparam int unsigned OpSrli  = 25;
  localparam int unsigned OpSrai  = 26;
  localparam int unsigned OpAdd   = 27;
  localparam int unsigned OpSub   = 28;
  localparam int unsigned OpSll   = 29;
  localparam int unsigned OpSlt   = 30;
  localparam int unsigned OpSltu  = 31;
  localparam int unsigned OpXor   = 32;
  localparam int unsigned OpSrl   = 33;
  localparam int unsigned OpSra   = 34;
  localparam int unsigned OpOr    = 35;
  localparam int unsigned OpAnd   = 36;

  logic [36:0] ins;
  assign ins = instrset_latched;

  // Instruction class decode
  logic op_add, op_sub, op_sll, op_srl, op_sra, op_slt, op_sltu, op_xor, op_or, op_and;
  logic is_rtype, is_alu, is_load, is_store, is_jump, size_half, size_word;
  logic no_multi, valid, illegal;

  assign op_add  = ins[OpAdd]  | ins[OpAddi];
  assign op_sub  = ins[OpSub];
  assign op_sll  = ins[OpSll]  | ins[OpSlli];
  assign op_srl  = ins[OpSrl]  | ins[OpSrli];
  assign op_sra  = ins[OpSra]  | ins[OpSrai];
  assign op_slt  = ins[OpSlt]  | ins[OpSlti];
  assign op_sltu = ins[OpSltu] | ins[OpSltiu];
  assign op_xor  = ins[OpXor]  | ins[OpXori];
  assign op_or   = ins[OpOr]   | ins[OpOri];
  assign op_and  = ins[OpAnd]  | ins[OpAndi];

  assign is_rtype = ins[OpAdd] | ins[OpSub] | ins[OpSll] | ins[OpSlt] | ins[OpSltu] |
                    ins[OpXor] | ins[OpSrl] | ins[OpSra] | ins[OpOr]  | ins[OpAnd];
  assign is_alu   = op_add | op_sub | op_sll | op_srl | op_sra | op_slt | op_sltu |
                    op_xor | op_or  | op_and;
  assign is_load  = ins[OpLb] | ins[OpLh] | ins[OpLw] | ins[OpLbu] | ins[OpLhu];
  assign is_store = ins[OpSb] | ins[OpSh] | ins[OpSw];
  assign is_jump  = ins[OpJal] | ins[OpJalr];
  assign size_half = ins[OpLh] | ins[OpLhu] | ins[OpSh];
  assign size_word = ins[OpLw] | ins[OpSw];

  // x & (x-1) clears the lowest set bit; nonzero means two or more bits set.
  assign no_multi = (ins & (ins - 37'd1)) == '0;
  assign valid    = (|ins) & no_multi;
  assign illegal  = (|ins) & ~no_multi;

  // Datapath
  logic [31:0] op2, alu_res, addr, pc_imm, pc_plus4, jalr_tgt, tgt;
  logic [4:0]  shamt;
  logic        rs_eq, rs_lt, rs_ltu, br_taken, take, misalign;

  assign op2      = is_rtype ? rs2_decoded : imm_decoded;
  assign shamt    = op2[4:0];
  assign addr     = rs1_decoded + imm_decoded;
  assign pc_imm   = pc_latched + imm_decoded;
  assign pc_plus4 = pc_latched + 32'd4;
  assign jalr_tgt = addr & ~32'h1;
  assign tgt      = ins[OpJalr] ? jalr_tgt : pc_imm;

  assign rs_eq  = rs1_decoded == rs2_decoded;
  assign rs_lt  = $signed(rs1_decoded) < $signed(rs2_decoded);
  assign rs_ltu = rs1_decoded < rs2_decoded;
  assign br_taken = (ins[OpBeq]  &  rs_eq)  | (ins[OpBne]  & ~rs_eq)  |
                    (ins[OpBlt]  &  rs_lt)  | (ins[OpBge]  & ~rs_lt)  |
                    (ins[OpBltu] &  rs_ltu) | (ins[OpBgeu] & ~rs_ltu);
  assign take = is_jump | br_taken;

`ifdef PRIRV32_EXU_MISALIGN_CHECK_EN
  assign misalign = valid & ((take & tgt[1]) | (size_half & addr[0]) |
                             (size_word & (addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    if (op_add)       alu_res = rs1_decoded + op2;
    else if (op_sub)  alu_res = rs1_decoded - op2;
    else if (op_sll)  alu_res = rs1_decoded << shamt;
    else if (op_srl)  alu_res = rs1_decoded >> shamt;
    else if (op_sra)  alu_res = $unsigned($signed(rs1_decoded) >>> shamt);
    else if (op_slt)  alu_res = {31'd0, $signed(rs1_decoded) < $signed(op2)};
    else if (op_sltu) alu_res = {31'd0, rs1_decoded < op2};
    else if (op_xor)  alu_res = rs1_decoded ^ op2;
    else if (op_or)   alu_res = rs1_decoded | op2;
    else if (op_and)  alu_res = rs1_decoded & op2;
  end

  // Output registers
  logic [4:0]  rd_addr_d, rd_addr_q, rs1_idx_d, rs1_idx_q, rs2_idx_d, rs2_idx_q;
  logic [31:0] rd_wdata_d, rd_wdata_q, branch_target_d, branch_target_q;
  logic [31:0] mem_addr_d, mem_addr_q, mem_wdata_d, mem_wdata_q;
  logic [3:0]  mem_wstrb_d, mem_wstrb_q;
  logic [1:0]  mem_size_d, mem_size_q;
  logic        rd_we_d, rd_we_q, branch_d, branch_q, mem_we_d, mem_we_q;
  logic        mem_re_d, mem_re_q, mem_unsigned_d, mem_unsigned_q;
  logic        illegal_d, illegal_q, misalign_d, misalign_q;

  always_comb begin
    // Data outputs hold across bubbles; enables and flags are single-cycle pulses.
    rd_addr_d       = rd_addr_q;
    rs1_idx_d       = rs1_idx_q;
    rs2_idx_d       = rs2_idx_q;
    rd_wdata_d      = rd_wdata_q;
    branch_target_d = branch_target_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_size_d      = mem_size_q;
    mem_wstrb_d     = '0;
    rd_we_d         = 1'b0;
    branch_d        = 1'b0;
    mem_we_d        = 1'b0;
    mem_re_d        = 1'b0;
    mem_unsigned_d  = 1'b0;
    illegal_d       = illegal;
    misalign_d      = misalign;

    if (valid) begin
      rd_addr_d       = rd_reg;
      rs1_idx_d       = rs1_reg;
      rs2_idx_d       = rs2_reg;
      branch_target_d = tgt;
      mem_addr_d      = addr;

      if (ins[OpLui])        rd_wdata_d = imm_decoded;
      else if (ins[OpAuipc]) rd_wdata_d = pc_imm;
      else if (is_jump)      rd_wdata_d = pc_plus4;
      else                   rd_wdata_d = alu_res;

      if (ins[OpSb])      mem_wdata_d = {4{rs2_decoded[7:0]}};
      else if (ins[OpSh]) mem_wdata_d = {2{rs2_decoded[15:0]}};
      else                mem_wdata_d = rs2_decoded;

      if (ins[OpSb])      mem_wstrb_d = 4'b0001 << addr[1:0];
      else if (ins[OpSh]) mem_wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
      else if (ins[OpSw]) mem_wstrb_d = 4'b1111;

      mem_size_d     = size_word ? 2'd2 : (size_half ? 2'd1 : 2'd0);
      mem_unsigned_d = ins[OpLbu] | ins[OpLhu];

      rd_we_d  = (is_alu | is_jump | ins[OpLui] | ins[OpAuipc]) & (rd_reg != 5'd0) & ~misalign;
      branch_d = take & ~misalign;
      mem_re_d = is_load & ~misalign;
      mem_we_d = is_store & ~misalign;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      rd_addr_q       <= '0;
      rs1_idx_q       <= '0;
      rs2_idx_q       <= '0;
      rd_wdata_q      <= '0;
      branch_target_q <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= '0;
      mem_size_q      <= '0;
      rd_we_q         <= 1'b0;
      branch_q        <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_re_q        <= 1'b0;
      mem_unsigned_q  <= 1'b0;
      illegal_q       <= 1'b0;
      misalign_q      <= 1'b0;
    end else begin
      rd_addr_q       <= rd_addr_d;
      rs1_idx_q       <= rs1_idx_d;
      rs2_idx_q       <= rs2_idx_d;
      rd_wdata_q      <= rd_wdata_d;
      branch_target_q <= branch_target_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wstrb_q     <= mem_wstrb_d;
      mem_size_q      <= mem_size_d;
      rd_we_q         <= rd_we_d;
      branch_q        <= branch_d;
      mem_we_q        <= mem_we_d;
      mem_re_q        <= mem_re_d;
      mem_unsigned_q  <= mem_unsigned_d;
      illegal_q       <= illegal_d;
      misalign_q      <= misalign_d;
    end
  end

  assign rd_addr_o       = rd_addr_q;
  assign rd_wdata_o      = rd_wdata_q;
  assign rd_we_o         = rd_we_q;
  assign branch_o        = branch_q;
  assign branch_target_o = branch_target_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wdata_o     = mem_wdata_q;
  assign mem_wstrb_o     = mem_wstrb_q;
  assign mem_we_o        = mem_we_q;
  assign mem_re_o        = mem_re_q;
  assign mem_size_o      = mem_size_q;
  assign mem_unsigned_o  = mem_unsigned_q;
  assign illegal_o       = illegal_q;
  assign misalign_o      = misalign_q;
  assign rs1_idx_o       = rs1_idx_q;
  assign rs2_idx_o       = rs2_idx_q;

endmodule

// File: tb/tb_prirv32_exu.sv
// Self-checking bench for prirv32_exu: directed vector table, hand-written
// reset/bubble/illegal sequences, then randomized instructions checked against
// an opcode-level reference model.

module tb_prirv32_exu;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [36:0] instrset_latched;
  logic [31:0] imm_decoded, rs1_decoded, rs2_decoded, pc_latched;
  logic [4:0]  rd_reg, rs1_reg, rs2_reg;
  logic [4:0]  rd_addr_o, rs1_idx_o, rs2_idx_o;
  logic [31:0] rd_wdata_o, branch_target_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [1:0]  mem_size_o;
  logic        rd_we_o, branch_o, mem_we_o, mem_re_o, mem_unsigned_o, illegal_o, misalign_o;

  always #5 clk_i = ~clk_i;

  prirv32_exu dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .instrset_latched(instrset_latched),
    .imm_decoded     (imm_decoded),
    .rs1_decoded     (rs1_decoded),
    .rs2_decoded     (rs2_decoded),
    .pc_latched      (pc_latched),
    .rd_reg          (rd_reg),
    .rs1_reg         (rs1_reg),
    .rs2_reg         (rs2_reg),
    .rd_addr_o       (rd_addr_o),
    .rd_wdata_o      (rd_wdata_o),
    .rd_we_o         (rd_we_o),
    .branch_o        (branch_o),
    .branch_target_o (branch_target_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_wstrb_o     (mem_wstrb_o),
    .mem_we_o        (mem_we_o),
    .mem_re_o        (mem_re_o),
    .mem_size_o      (mem_size_o),
    .mem_unsigned_o  (mem_unsigned_o),
    .illegal_o       (illegal_o),
    .misalign_o      (misalign_o),
    .rs1_idx_o       (rs1_idx_o),
    .rs2_idx_o       (rs2_idx_o)
  );

  int checks = 0;
  int failures = 0;

  // Expected register indices; these only change on a legal instruction.
  logic [4:0] h_rd = '0, h_rs1 = '0, h_rs2 = '0;

  typedef struct packed {
    logic        chk_wd, chk_tgt, chk_ld, chk_st;
    logic        rd_we, branch, mem_we, mem_re, illegal, misalign, uns;
    logic [31:0] wdata, tgt, addr, mwdata;
    logic [3:0]  strb;
    logic [1:0]  size;
  } exp_t;

  typedef struct packed {
    int          op;   // -2 = illegal (bits 27 and 28), otherwise opcode bit index
    logic [31:0] a, b, imm, pc;
    logic [4:0]  rd;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_exp(input exp_t e);
    chk("rd_we", {31'd0, rd_we_o}, {31'd0, e.rd_we});
    chk("branch", {31'd0, branch_o}, {31'd0, e.branch});
    chk("mem_we", {31'd0, mem_we_o}, {31'd0, e.mem_we});
    chk("mem_re", {31'd0, mem_re_o}, {31'd0, e.mem_re});
    chk("illegal", {31'd0, illegal_o}, {31'd0, e.illegal});
    chk("misalign", {31'd0, misalign_o}, {31'd0, e.misalign});
    chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, h_rd});
    chk("rs1_idx", {27'd0, rs1_idx_o}, {27'd0, h_rs1});
    chk("rs2_idx", {27'd0, rs2_idx_o}, {27'd0, h_rs2});
    if (e.chk_wd) chk("rd_wdata", rd_wdata_o, e.wdata);
    if (e.chk_tgt) chk("branch_target", branch_target_o, e.tgt);
    if (e.chk_ld || e.chk_st) begin
      chk("mem_addr", mem_addr_o, e.addr);
      chk("mem_size", {30'd0, mem_size_o}, {30'd0, e.size});
    end
    if (e.chk_ld) chk("mem_unsigned", {31'd0, mem_unsigned_o}, {31'd0, e.uns});
    if (e.chk_st) begin
      chk("mem_wdata", mem_wdata_o, e.mwdata);
      chk("mem_wstrb", {28'd0, mem_wstrb_o}, {28'd0, e.strb});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_addr"}, {27'd0, rd_addr_o}, 32'd0);
    chk({tag, "_rd_wdata"}, rd_wdata_o, 32'd0);
    chk({tag, "_target"}, branch_target_o, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_flags"}, {16'd0, mem_wstrb_o, mem_size_o, rd_we_o, branch_o, mem_we_o,
                          mem_re_o, mem_unsigned_o, illegal_o, misalign_o},
        32'd0);
    chk({tag, "_idx"}, {22'd0, rs1_idx_o, rs2_idx_o}, 32'd0);
  endtask

  // Reference model working from opcode semantics.
  function automatic exp_t model(input int op, input logic [36:0] ins, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm,
                                 input logic [31:0] pc, input logic [4:0] rd);
    exp_t e;
    logic [31:0] op2, addr, res;
    logic [4:0]  sh;
    logic        wr;
    e = '0;
    wr = 1'b0;
    res = '0;
    op2 = (op >= 27) ? b : imm;
    sh = op2[4:0];
    addr = a + imm;
    if (op < 0) begin
      e.illegal = (ins != '0);
      return e;
    end
    case (op)
      0: begin wr = 1'b1; res = imm; end
      1: begin wr = 1'b1; res = pc + imm; end
      2: begin wr = 1'b1; res = pc + 32'd4; e.branch = 1'b1; e.tgt = pc + imm; end
      3: begin wr = 1'b1; res = pc + 32'd4; e.branch = 1'b1; e.tgt = (a + imm) & 32'hFFFF_FFFE; end
      4: e.branch = (a == b);
      5: e.branch = (a != b);
      6: e.branch = ($signed(a) < $signed(b));
      7: e.branch = ($signed(a) >= $signed(b));
      8: e.branch = (a < b);
      9: e.branch = (a >= b);
      10, 11, 12, 13, 14: begin
        e.chk_ld = 1'b1;
        e.mem_re = 1'b1;
        e.addr = addr;
        e.size = (op == 12) ? 2'd2 : ((op == 11 || op == 14) ? 2'd1 : 2'd0);
        e.uns = (op == 13 || op == 14);
      end
      15: begin
        e.chk_st = 1'b1; e.mem_we = 1'b1; e.addr = addr; e.size = 2'd0;
        e.mwdata = {b[7:0], b[7:0], b[7:0], b[7:0]};
        case (addr[1:0])
          2'd0: e.strb = 4'b0001;
          2'd1: e.strb = 4'b0010;
          2'd2: e.strb = 4'b0100;
          default: e.strb = 4'b1000;
        endcase
      end
      16: begin
        e.chk_st = 1'b1; e.mem_we = 1'b1; e.addr = addr; e.size = 2'd1;
        e.mwdata = {b[15:0], b[15:0]};
        e.strb = addr[1] ? 4'b1100 : 4'b0011;
      end
      17: begin
        e.chk_st = 1'b1; e.mem_we = 1'b1; e.addr = addr; e.size = 2'd2;
        e.mwdata = b; e.strb = 4'b1111;
      end
      18, 27: begin wr = 1'b1; res = a + op2; end
      28:     begin wr = 1'b1; res = a - op2; end
      19, 30: begin wr = 1'b1; res = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0; end
      20, 31: begin wr = 1'b1; res = (a < op2) ? 32'd1 : 32'd0; end
      21, 32: begin wr = 1'b1; res = a ^ op2; end
      22, 35: begin wr = 1'b1; res = a | op2; end
      23, 36: begin wr = 1'b1; res = a & op2; end
      24, 29: begin wr = 1'b1; res = a << sh; end
      25, 33: begin wr = 1'b1; res = a >> sh; end
      default: begin wr = 1'b1; res = $unsigned($signed(a) >>> sh); end
    endcase
    if (op >= 4 && op <= 9) e.tgt = pc + imm;
    e.chk_tgt = e.branch;
    e.chk_wd = wr;
    e.wdata = res;
    e.rd_we = wr && (rd != 5'd0);
`ifdef PRIRV32_EXU_MISALIGN_CHECK_EN
    e.misalign = (e.branch && e.tgt[1]) ||
                 ((op == 11 || op == 14 || op == 16) && addr[0]) ||
                 ((op == 12 || op == 17) && addr[1:0] != 2'b00);
    if (e.misalign) begin
      e.rd_we = 1'b0; e.branch = 1'b0; e.mem_we = 1'b0; e.mem_re = 1'b0;
      e.chk_tgt = 1'b0;
    end
`endif
    return e;
  endfunction

  function automatic logic [36:0] ins_of(input int op);
    logic [36:0] one;
    one = 37'd1;
    if (op >= 0) return one << op;
    if (op == -2) return (one << 27) | (one << 28);
    return '0;
  endfunction

  // Present one instruction, clock it in, then update the tracked indices.
  task automatic drive(input logic [36:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2);
    instrset_latched = ins;
    rs1_decoded = a;
    rs2_decoded = b;
    imm_decoded = imm;
    pc_latched = pc;
    rd_reg = rd;
    rs1_reg = r1;
    rs2_reg = r2;
    @(posedge clk_i);
    #1;
    if (rst_n) begin
      h_rd = '0; h_rs1 = '0; h_rs2 = '0;
    end else if ($onehot(ins)) begin
      h_rd = rd; h_rs1 = r1; h_rs2 = r2;
    end
  endtask

  function automatic vec_t mkv(input int op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic [4:0] rd, input logic we, input logic [31:0] wd,
                               input logic br, input logic [31:0] tgt);
    vec_t v;
    v = '0;
    v.op = op; v.a = a; v.b = b; v.imm = imm; v.pc = pc; v.rd = rd;
    v.e.rd_we = we; v.e.chk_wd = we; v.e.wdata = wd;
    v.e.branch = br; v.e.chk_tgt = br; v.e.tgt = tgt;
    return v;
  endfunction

  vec_t vecs[12];
  exp_t e;

  initial begin
    // Directed vectors with hand-derived expectations.
    vecs[0]  = mkv(27, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd5, 1'b1, 32'h0, 1'b0, 32'd0);
    vecs[1]  = mkv(28, 32'd0, 32'd1, 32'd0, 32'd0, 5'd6, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0);
    vecs[2]  = mkv(34, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 5'd7, 1'b1, 32'hC000_0000, 1'b0, 32'd0);
    vecs[3]  = mkv(33, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 5'd7, 1'b1, 32'h4000_0000, 1'b0, 32'd0);
    vecs[4]  = mkv(6, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd8, 1'b0, 32'd0, 1'b1, 32'h120);
    vecs[5]  = mkv(8, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd8, 1'b0, 32'd0, 1'b0, 32'd0);
    vecs[6]  = mkv(3, 32'h1001, 32'd0, 32'd4, 32'h40, 5'd1, 1'b1, 32'h44, 1'b1, 32'h1004);
    vecs[7]  = mkv(3, 32'h1001, 32'd0, 32'd4, 32'h40, 5'd0, 1'b0, 32'd0, 1'b1, 32'h1004);
    vecs[8]  = mkv(15, 32'h2000, 32'hAB, 32'd3, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    vecs[8].e.chk_st = 1'b1; vecs[8].e.mem_we = 1'b1; vecs[8].e.addr = 32'h2003;
    vecs[8].e.strb = 4'b1000; vecs[8].e.mwdata = 32'hABAB_ABAB;
    vecs[9]  = mkv(-2, 32'd3, 32'd4, 32'd0, 32'd0, 5'd9, 1'b0, 32'd0, 1'b0, 32'd0);
    vecs[9].e.illegal = 1'b1;
    vecs[10] = mkv(0, 32'd0, 32'd0, 32'h1234_5000, 32'h80, 5'd3, 1'b1, 32'h1234_5000, 1'b0, 32'd0);
    vecs[11] = mkv(31, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd4, 1'b1, 32'd1, 1'b0, 32'd0);

    // Reset held for two edges with an ADD presented: everything stays cleared.
    rst_n = 1'b1;
    drive(ins_of(27), 32'd7, 32'd8, 32'd1, 32'h40, 5'd3, 5'd1, 5'd2);
    chk_all_zero("reset1");
    drive(ins_of(27), 32'd7, 32'd8, 32'd1, 32'h40, 5'd3, 5'd1, 5'd2);
    chk_all_zero("reset2");

    // First result one cycle after release.
    rst_n = 1'b0;
    drive(ins_of(27), 32'd1, 32'd2, 32'd0, 32'd0, 5'd9, 5'd10, 5'd11);
    check_exp(model(27, ins_of(27), 32'd1, 32'd2, 32'd0, 32'd0, 5'd9));

    // Bubble: enables drop, data holds.
    drive('0, 32'h55, 32'h66, 32'd0, 32'd0, 5'd20, 5'd21, 5'd22);
    check_exp(model(-1, '0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0));
    chk("bubble_hold_wdata", rd_wdata_o, 32'd3);

    // Directed table.
    foreach (vecs[i]) begin
      drive(ins_of(vecs[i].op), vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc, vecs[i].rd,
            5'(i), 5'(i + 1));
      check_exp(vecs[i].e);
    end

    // Illegal is a one-cycle pulse.
    drive('0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    chk("illegal_pulse_end", {31'd0, illegal_o}, 32'd0);

    // Mid-stream reset drops the in-flight result.
    drive(ins_of(27), 32'd5, 32'd6, 32'd0, 32'd0, 5'd4, 5'd1, 5'd1);
    chk("pre_reset_add", rd_wdata_o, 32'd11);
    rst_n = 1'b1;
    drive(ins_of(27), 32'd5, 32'd6, 32'd0, 32'd0, 5'd4, 5'd1, 5'd1);
    chk_all_zero("midreset");
    rst_n = 1'b0;

    // Randomized instructions against the model.
    for (int n = 0; n < 600; n++) begin
      int op;
      logic [36:0] ins;
      logic [31:0] a, b, imm, pc;
      logic [4:0]  rd, r1, r2;
      int sel;
      sel = $urandom_range(0, 39);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm = 32'($signed(12'($urandom)));
      pc = $urandom & 32'hFFFF_FFFC;
      rd = 5'($urandom);
      r1 = 5'($urandom);
      r2 = 5'($urandom);
      if (sel == 37) begin
        op = -1;
        ins = '0;
      end else if (sel >= 38) begin
        int b1, b2;
        logic [36:0] one;
        one = 37'd1;
        b1 = $urandom_range(0, 36);
        b2 = (b1 + 1 + $urandom_range(0, 35)) % 37;
        op = -2;
        ins = (one << b1) | (one << b2);
      end else begin
        op = sel;
        ins = ins_of(op);
        if (op == 0 || op == 1) imm = $urandom & 32'hFFFF_F000;
      end
      e = model(op, ins, a, b, imm, pc, rd);
      drive(ins, a, b, imm, pc, rd, r1, r2);
      check_exp(e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prirv32_exu.md
# prirv32_exu

Single-cycle-latency execute unit of the priRV32 RV32I core. It sits between the decode stage and the writeback/LSU stage. It takes a one-hot decoded instruction with its operand values, immediate and PC, and produces a registered result: register writeback, branch/jump redirect, or a memory request. It holds no architectural state beyond its output registers.

## Interface
- No parameters.
- clk_i  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-high reset. The name follows the codebase, but the signal is asserted high.
- instrset_latched  input  37  one-hot decoded instruction. Bit order 0..36: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LB, LH, LW, LBU, LHU, SB, SH, SW, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- imm_decoded  input  32  sign-extended immediate. For LUI/AUIPC it is already shifted (imm<<12).
- rs1_decoded  input  32  rs1 operand value.
- rs2_decoded  input  32  rs2 operand value.
- pc_latched  input  32  PC of the instruction.
- rd_reg  input  5  destination register index.
- rs1_reg, rs2_reg  input  5  source indices. They are passed through to rs1_idx_o and rs2_idx_o for hazard logic.
- rd_addr_o  output  5  registered destination index.
- rd_wdata_o  output  32  writeback value.
- rd_we_o  output  1  writeback enable.
- branch_o  output  1  redirect PC.
- branch_target_o  output  32  redirect address.
- mem_addr_o  output  32  load/store byte address.
- mem_wdata_o  output  32  store data, lane-replicated.
- mem_wstrb_o  output  4  byte strobes.
- mem_we_o, mem_re_o  output  1  store / load request.
- mem_size_o  output  2  0 = byte, 1 = half, 2 = word.
- mem_unsigned_o  output  1  LBU/LHU zero-extend.
- illegal_o  output  1  instrset_latched was not one-hot and not zero.
- misalign_o  output  1  misalignment flag; see Configuration.
- rs1_idx_o, rs2_idx_o  output  5  registered source indices.

## Operation
- **ALU ops**
  - op2 is imm_decoded for I-type and rs2_decoded for R-type.
  - Shift amount is op2[4:0].
  - SRA/SRAI are arithmetic shifts.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. Result is 1 or 0.
  - Add/sub wrap modulo 2^32.
- **LUI / AUIPC:** LUI writes imm; AUIPC writes pc+imm.
- **JAL / JALR**
  - Both write pc+4 and assert branch_o.
  - JAL target = pc+imm.
  - JALR target = (rs1+imm) & ~1.
- **Branches**
  - Compare rs1 with rs2: signed for BLT/BGE, unsigned for BLTU/BGEU.
  - When taken: branch_o=1, target = pc+imm. When not taken: branch_o=0.
  - Branches never write rd.
- **Loads**
  - mem_addr = rs1+imm, mem_re_o=1.
  - mem_size and mem_unsigned are set per opcode.
  - rd_we_o=0; the LSU performs the writeback using rd_addr_o.
- **Stores**
  - mem_addr = rs1+imm, mem_we_o=1.
  - SB: data = {4{rs2[7:0]}}, wstrb = 1<<addr[1:0].
  - SH: data = {2{rs2[15:0]}}, wstrb = 0011 or 1100 selected by addr[1].
  - SW: data = rs2, wstrb = 1111.
- **rd = x0:** rd_we_o is forced 0. Other effects still occur.
- **Bubble** (instrset all zero): every enable/flag output is 0 and data outputs hold their previous values.
- **Illegal** (more than one bit set): treated as a bubble, plus illegal_o=1 for one cycle.
- Enables not relevant to the current opcode are 0.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N, valid during cycle N+1.
- A new instruction is accepted every cycle. There is no handshake and no stall input.
- All outputs are registered.
- On any rising edge with rst_n=1, every output is cleared to 0, regardless of inputs. Inputs presented on that edge are discarded.
- Reset asserted mid-stream drops the in-flight result.
- Enables and flags are pulses. They stay high only in cycles following an edge that sampled a qualifying instruction.

## Configuration
- PRIRV32_EXU_MISALIGN_CHECK_EN
  - **Defined:**
    - misalign_o=1 when any of the following holds:
      - a taken branch or jump target has bit1 set;
      - LH/LHU/SH has addr[0]=1;
      - LW/SW has addr[1:0]≠0.
    - When misalign_o=1: branch_o, mem_we_o, mem_re_o and rd_we_o are 0 that cycle.
  - **Undefined:** misalign_o is tied 0 and addresses pass unchecked.

## Test plan
- **Reset:** hold rst_n=1 for 2 edges with ADD asserted -> all outputs 0. Release -> first result one cycle later.
- **ADD / SUB**
  - ADD with rs1=0xFFFFFFFF, rs2=1, rd=5 -> rd_wdata_o=0, rd_we_o=1, rd_addr_o=5.
  - SUB with rs1=0, rs2=1 -> 0xFFFFFFFF.
- **Shifts:** SRA with rs1=0x80000000, rs2=0x21 -> 0xC0000000. SRL with the same operands -> 0x40000000.
- **Branches**
  - BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> branch_o=1, target=0x120.
  - BLTU with the same operands -> branch_o=0.
- **JALR / x0:** JALR with rs1=0x1001, imm=4, pc=0x40, rd=1 -> target=0x1004, rd_wdata_o=0x44. Same with rd=0 -> rd_we_o=0.
- **Store / illegal**
  - SB with rs1=0x2000, imm=3, rs2=0xAB -> addr=0x2003, wstrb=1000, wdata=0xABABABAB, mem_we_o=1.
  - instrset with two bits set -> illegal_o=1 and all enables 0.
